// File: rtl/floor_disp_pkg.sv
// Shared segment codes, controller state type and BCD-to-segment decode for the floor display.
// Pure declarations: no latency, no handshake.
package floor_disp_pkg;

   localparam logic [7:0] SEG_0     = 8'b1100_0000;
   localparam logic [7:0] SEG_1     = 8'b1111_1001;
   localparam logic [7:0] SEG_2     = 8'b1010_0100;
   localparam logic [7:0] SEG_3     = 8'b1011_0000;
   localparam logic [7:0] SEG_4     = 8'b1001_1001;
   localparam logic [7:0] SEG_5     = 8'b1001_0010;
   localparam logic [7:0] SEG_6     = 8'b1000_0010;
   localparam logic [7:0] SEG_7     = 8'b1111_1000;
   localparam logic [7:0] SEG_8     = 8'b1000_0000;
   localparam logic [7:0] SEG_9     = 8'b1001_0000;
   localparam logic [7:0] SEG_BLANK = 8'b1111_1111;
   localparam logic [7:0] SEG_DASH  = 8'b1011_1111;

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   // Active-low segments with dp off; non-decimal nibbles render blank.
   function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD engine: FW cycles from start, done flags the final shift cycle.
// start is accepted only while idle; requests during a conversion are dropped.
module bin2bcd_seq
   import floor_disp_pkg::*;
#(
   parameter int FW   = 4,
   parameter int NDIG = 2
) (
   input  logic                clk,
   input  logic                resetb,
   input  logic                start,
   input  logic [FW-1:0]       bin,
   output logic                busy,
   output logic                done,
   output logic [FW-1:0]       value,
   output logic [4*NDIG-1:0]   bcd
);

   localparam int CW = (FW > 1) ? $clog2(FW) : 1;

   logic [FW-1:0]     sh;
   logic [CW-1:0]     cnt;
   logic              run;
   logic [4*NDIG-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < NDIG; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         run   <= 1'b0;
         cnt   <= '0;
         sh    <= '0;
         value <= '0;
         bcd   <= '0;
      end else if (run) begin
         bcd <= {adj[4*NDIG-2:0], sh[FW-1]};
         sh  <= sh << 1;
         if (cnt == CW'(FW-1)) begin
            run <= 1'b0;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else if (start) begin
         run   <= 1'b1;
         cnt   <= '0;
         sh    <= bin;
         value <= bin;
         bcd   <= '0;
      end
   end

   assign busy = run;
   assign done = run && (cnt == CW'(FW-1));

endmodule

// File: rtl/floor_disp_mux.sv
// Floor number to NDIG multiplexed active-low 7-seg digits; new value shows FW+2 clk after slowref.
// No backpressure: slowref while converting is dropped. Optional blink while moving under BLINK_EN.
module floor_disp_mux
   import floor_disp_pkg::*;
#(
   parameter int FW     = 4,
   parameter int NDIG   = 2,
   parameter int NFLOOR = 10,
   parameter int REFDIV = 50000
) (
   input  logic            clk,
   input  logic            resetb,
   input  logic            slowref,
   input  logic [FW-1:0]   floorno,
   input  logic            moving,
   output logic [7:0]      segdisp,
   output logic [NDIG-1:0] andisp,
   output logic            busy
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int PW = $clog2(REFDIV);

   state_t            state;
   logic              eng_start;
   logic              eng_busy;
   logic              eng_done;
   logic [FW-1:0]     eng_val;
   logic [4*NDIG-1:0] eng_bcd;

   assign eng_start = (state == IDLE) && slowref;

   bin2bcd_seq #(.FW(FW), .NDIG(NDIG)) u_conv (
      .clk    (clk),
      .resetb (resetb),
      .start  (eng_start),
      .bin    (floorno),
      .busy   (eng_busy),
      .done   (eng_done),
      .value  (eng_val),
      .bcd    (eng_bcd)
   );

   assign busy = eng_busy;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (slowref) state <= CONV;
            CONV:    if (eng_done) state <= LOAD;
            LOAD:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   logic       oor;
   logic       lead;
   logic [3:0] nib;
   logic [7:0] code     [NDIG];
   logic [7:0] disp     [NDIG];
   logic [7:0] disp_nxt [NDIG];

   assign oor = 32'(eng_val) >= 32'(NFLOOR);

   // Walk from the most significant digit so zeros are blanked until the first nonzero one.
   always_comb begin
      lead = 1'b1;
      nib  = '0;
      code = '{default: SEG_BLANK};
      for (int i = NDIG-1; i >= 0; i--) begin
         nib = eng_bcd[4*i +: 4];
         if (oor) begin
            code[i] = SEG_DASH;
         end else if (lead && (i != 0) && (nib == 4'd0)) begin
            code[i] = SEG_BLANK;
         end else begin
            code[i] = bcd_to_seg(nib);
            lead    = 1'b0;
         end
      end
   end

   always_comb begin
      disp_nxt = disp;
      if (state == LOAD) disp_nxt = code;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < NDIG; i++) disp[i] <= SEG_BLANK;
      end else begin
         disp <= disp_nxt;
      end
   end

   logic [PW-1:0] pre;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_nxt;
   logic          tc;
   logic          blank_now;

   assign tc = (pre == PW'(REFDIV-1));

   always_comb begin
      idx_nxt = idx;
      if (tc) idx_nxt = (idx == IW'(NDIG-1)) ? '0 : idx + IW'(1);
   end

   // segdisp reads the next-state display so a LOAD shows up in the same cycle as the register write.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         pre     <= '0;
         idx     <= '0;
         andisp  <= '1;
         segdisp <= SEG_BLANK;
      end else begin
         pre     <= tc ? '0 : pre + PW'(1);
         idx     <= idx_nxt;
         andisp  <= ~(NDIG'(1) << idx_nxt);
         segdisp <= blank_now ? SEG_BLANK : disp_nxt[idx_nxt];
      end
   end

`ifdef BLINK_EN
   localparam int BLINKSH = 6;

   logic [BLINKSH-1:0] wraps;
   logic               blink;
   logic               scan_wrap;

   assign scan_wrap = tc && (idx == IW'(NDIG-1));

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wraps <= '0;
         blink <= 1'b0;
      end else if (!moving) begin
         wraps <= '0;
         blink <= 1'b0;
      end else if (scan_wrap) begin
         wraps <= wraps + BLINKSH'(1);
         if (wraps == '1) blink <= ~blink;
      end
   end

   assign blank_now = moving && blink;
`else
   logic unused_moving;

   assign unused_moving = moving;
   assign blank_now     = 1'b0;
`endif

endmodule

// File: tb/tb_floor_disp_mux.sv
// Randomised bench for floor_disp_mux against a decimal-arithmetic display model, plus literal spot checks.
module tb_floor_disp_mux;

   localparam int FW     = 5;
   localparam int NDIG   = 2;
   localparam int NFLOOR = 20;
   localparam int REFDIV = 5;

   logic            clk;
   logic            resetb;
   logic            slowref;
   logic [FW-1:0]   floorno;
   logic            moving;
   logic [7:0]      segdisp;
   logic [NDIG-1:0] andisp;
   logic            busy;

   int vectors     = 0;
   int miscompares = 0;

   floor_disp_mux #(.FW(FW), .NDIG(NDIG), .NFLOOR(NFLOOR), .REFDIV(REFDIV)) dut (
      .clk     (clk),
      .resetb  (resetb),
      .slowref (slowref),
      .floorno (floorno),
      .moving  (moving),
      .segdisp (segdisp),
      .andisp  (andisp),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_code(input int val, input int dig);
      int p = 1;
      if (val >= NFLOOR) return 8'hBF;
      for (int k = 0; k < dig; k++) p = p * 10;
      if (dig > 0 && val < p) return 8'hFF;
      return segtab[(val / p) % 10];
   endfunction

   // Model: n counts clk edges since reset release; phase counts edges since an accepted update.
   int         n;
   int         phase;
   int         mval;
   logic [7:0] mdisp [NDIG];

   always @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         n     = 0;
         phase = 0;
         for (int i = 0; i < NDIG; i++) mdisp[i] = 8'hFF;
      end else begin
         n++;
         if (phase == 0) begin
            if (slowref) begin
               phase = 1;
               mval  = int'(floorno);
            end
         end else if (phase == FW + 1) begin
            for (int i = 0; i < NDIG; i++) mdisp[i] = exp_code(mval, i);
            phase = 0;
         end else begin
            phase++;
         end
      end
   end

   always @(negedge clk) begin
      int              cidx;
      logic [NDIG-1:0] ean;
      logic [7:0]      eseg;
      if (n == 0) begin
         ean  = '1;
         eseg = 8'hFF;
      end else begin
         cidx = (n / REFDIV) % NDIG;
         ean  = ~(NDIG'(1) << cidx);
         eseg = mdisp[cidx];
      end
      chk("model_segdisp", segdisp, eseg);
      chk("model_andisp", andisp, ean);
      chk("model_busy", busy, (phase >= 1 && phase <= FW));
   end

   task automatic dig(input logic [NDIG-1:0] an, input logic [7:0] exp, input string nm);
      int k = 0;
      while (andisp !== an && k < 4*REFDIV) begin
         @(negedge clk);
         k++;
      end
      if (andisp !== an) chk({nm, "_slot"}, andisp, an);
      else               chk(nm, segdisp, exp);
   endtask

   task automatic pulse(input int f);
      floorno = FW'(f);
      slowref = 1'b1;
      @(negedge clk);
      slowref = 1'b0;
   endtask

   task automatic count_busy(input int exp, input string nm);
      int c = 0;
      repeat (FW + 3) begin
         if (busy) c++;
         @(negedge clk);
      end
      chk(nm, c, exp);
   endtask

   initial begin
      resetb  = 1'b0;
      slowref = 1'b0;
      floorno = '0;
      moving  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_segdisp", segdisp, 8'hFF);
      chk("rst_andisp", andisp, 2'b11);
      chk("rst_busy", busy, 1'b0);
      resetb = 1'b1;
      @(negedge clk);
      chk("scan_first", andisp, 2'b10);
      repeat (REFDIV) @(negedge clk);
      chk("scan_second", andisp, 2'b01);

      pulse(7);
      count_busy(FW, "busy_len_7");
      dig(2'b10, 8'hF8, "f7_d0");
      dig(2'b01, 8'hFF, "f7_d1");

      pulse(12);
      count_busy(FW, "busy_len_12");
      dig(2'b10, 8'hA4, "f12_d0");
      dig(2'b01, 8'hF9, "f12_d1");
      floorno = 5'd3;
      repeat (2*REFDIV) @(negedge clk);
      dig(2'b10, 8'hA4, "hold_d0");
      dig(2'b01, 8'hF9, "hold_d1");

      pulse(25);
      count_busy(FW, "busy_len_25");
      dig(2'b10, 8'hBF, "oor_d0");
      dig(2'b01, 8'hBF, "oor_d1");

      pulse(12);
      @(negedge clk);
      pulse(7);
      count_busy(FW - 2, "busy_collide");
      dig(2'b10, 8'hA4, "collide_d0");
      dig(2'b01, 8'hF9, "collide_d1");

      pulse(9);
      @(negedge clk);
      #2 resetb = 1'b0;
      #1;
      chk("midrst_segdisp", segdisp, 8'hFF);
      chk("midrst_andisp", andisp, 2'b11);
      chk("midrst_busy", busy, 1'b0);
      @(negedge clk);
      resetb = 1'b1;
      repeat (FW + 4) @(negedge clk);
      chk("postrst_busy", busy, 1'b0);
      dig(2'b10, 8'hFF, "postrst_d0");
      dig(2'b01, 8'hFF, "postrst_d1");

      for (int c = 0; c < 3000; c++) begin
         slowref = ($urandom_range(0, 9) == 0);
         floorno = FW'($urandom_range(0, 31));
         moving  = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      slowref = 1'b0;
      repeat (FW + 4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
